// File: rtl/posit_64_4_pkg.sv
// rtl/posit_64_4_pkg.sv - posit<64,4> encoder constants and pipeline types
package posit_64_4_pkg;

  localparam int N    = 64;
  localparam int ES   = 4;
  localparam int RS   = 7;
  localparam int FS   = N - 3 - ES;
  localparam int WIDE = 128;

  localparam logic [N-1:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [N-1:0] MINPOS = 64'h0000_0000_0000_0001;
  localparam logic [N-1:0] NAR    = 64'h8000_0000_0000_0000;

  localparam logic signed [RS-1:0] K_SAT_HI = 7'sd62;
  localparam logic signed [RS-1:0] K_SAT_LO = -7'sd63;

  typedef struct packed {
    logic          sign;
    logic [RS-1:0] regi;
    logic [ES-1:0] expo;
    logic [FS-1:0] frac;
    logic          zero;
    logic          nar;
  } posit_fields_t;

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          nar;
    logic          sat_hi;
    logic          sat_lo;
    logic [N-2:0]  body;
    logic          g;
    logic          s;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          nar;
    logic [N-2:0]  body;
  } s2_t;

endpackage

// File: rtl/posit_round_rne.sv
// rtl/posit_round_rne.sv - round-to-nearest-even increment of a 63-bit posit body
module posit_round_rne
  import posit_64_4_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic [N-2:0] body_i,
  input  logic         g_i,
  input  logic         s_i,
  output logic [N-2:0] body_o,
  output logic         ovf_o
);

  logic         round_up;
  logic [N-1:0] sum;

  assign round_up = ROUND_EN & g_i & (s_i | body_i[0]);
  assign sum      = {1'b0, body_i} + {{(N-1){1'b0}}, round_up};
  assign body_o   = sum[N-2:0];
  assign ovf_o    = sum[N-1];

endmodule

// File: rtl/posit_64_4_encoder.sv
// rtl/posit_64_4_encoder.sv - pipelined posit<64,4> field-to-word encoder
// POSIT_ENC_ROUND_EN selects RNE rounding; otherwise the body is truncated.
module posit_64_4_encoder
  import posit_64_4_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [RS-1:0] in_regi,
  input  logic [ES-1:0] in_expo,
  input  logic [FS-1:0] in_frac,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

`ifdef POSIT_ENC_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic          advance;
  posit_fields_t in_fields;
  posit_fields_t f_q;
  logic          v0_q, v1_q, v2_q, out_valid_q;
  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  logic [N-1:0]  out_posit_d, out_posit_q;

  logic            run_bit;
  logic [RS-1:0]   run_len;
  logic [WIDE-1:0] seed, fill, wide;
  logic [N-2:0]    rnd_body;
  logic            rnd_ovf;
  logic [N-1:0]    body64;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;
  assign in_fields = '{sign: in_sign, regi: in_regi, expo: in_expo,
                       frac: in_frac, zero: in_zero, nar: in_nar};

  // Regime is a run of run_bit; shifting the terminator+expo+frac right by the run length
  // and back-filling with run_bit yields the left-aligned body, guard and sticky tail.
  always_comb begin
    run_bit     = ~f_q.regi[RS-1];
    run_len     = run_bit ? (f_q.regi + RS'(1)) : (~f_q.regi + RS'(1));
    seed        = {~run_bit, f_q.expo, f_q.frac, {(WIDE-ES-FS-1){1'b0}}};
    fill        = run_bit ? ~({WIDE{1'b1}} >> run_len) : '0;
    wide        = (seed >> run_len) | fill;
    s1_d.sign   = f_q.sign;
    s1_d.zero   = f_q.zero;
    s1_d.nar    = f_q.nar;
    s1_d.sat_hi = $signed(f_q.regi) >= K_SAT_HI;
    s1_d.sat_lo = $signed(f_q.regi) <= K_SAT_LO;
    s1_d.body   = wide[WIDE-1 -: N-1];
    s1_d.g      = wide[WIDE-N];
    s1_d.s      = |wide[WIDE-N-1:0];
  end

  posit_round_rne #(.ROUND_EN(ROUND_EN)) u_round (
    .body_i (s1_q.body),
    .g_i    (s1_q.g),
    .s_i    (s1_q.s),
    .body_o (rnd_body),
    .ovf_o  (rnd_ovf)
  );

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.nar  = s1_q.nar;
    if (s1_q.sat_hi || rnd_ovf) begin
      s2_d.body = MAXPOS[N-2:0];
    end else if (s1_q.sat_lo || (rnd_body == '0)) begin
      s2_d.body = MINPOS[N-2:0];
    end else begin
      s2_d.body = rnd_body;
    end
  end

  always_comb begin
    body64 = {1'b0, s2_q.body};
    if (s2_q.nar) begin
      out_posit_d = NAR;
    end else if (s2_q.zero) begin
      out_posit_d = '0;
    end else if (s2_q.sign) begin
      out_posit_d = -body64;
    end else begin
      out_posit_d = body64;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q         <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else if (advance) begin
      f_q         <= in_fields;
      v0_q        <= in_valid;
      s1_q        <= s1_d;
      v1_q        <= v0_q;
      s2_q        <= s2_d;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      out_posit_q <= out_posit_d;
    end
  end

endmodule

// File: doc/posit_64_4_encoder.md
Name: posit_64_4_encoder

Overview:
- Pipelined posit<64,4> encoder. It is the inverse of the team's posit<64,4> field decoder.
- Accepts decoded fields (sign, regime k, exponent, fraction, zero/NaR flags) and packs them into a 64-bit posit word, with round-to-nearest-even and saturation.
- Sits at the output of the posit arithmetic datapath (adder/multiplier normalisers), ahead of the register file write-back.
- Uses a valid/ready handshake and a 3-stage pipeline.

Parameters:
- N, 64, posit word width
- ES, 4, exponent field width
- RS, 7, regime value width (two's complement k)
- FS, 57, fraction width (N-3-ES), MSB-aligned, hidden bit excluded

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept this cycle
- in_sign  input  1  sign of the value
- in_regi  input  RS  regime value k, two's complement, legal range -63..62
- in_expo  input  ES  exponent field
- in_frac  input  FS  fraction bits, MSB first
- in_zero  input  1  value is exactly zero
- in_nar  input  1  value is NaR
- out_valid  output  1  out_posit valid
- out_ready  input  1  downstream accepts
- out_posit  output  N  encoded posit word

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valids, out_valid and out_posit are set to 0. In-flight data is discarded. in_ready is 1 in the first cycle after reset.
- Handshake:
  - A transfer occurs on an edge where valid&&ready.
  - Global stall: advance = ~out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage holds and out_posit stays stable.
  - out_valid must not drop without a transfer.
  - Latency is 3 cycles (input accepted at edge t, out_valid at edge t+3) with no bubbles. Throughput is 1 per cycle.
- S1, regime build and body assembly:
  - k>=0: regime is (k+1) ones followed by a zero, length k+2.
  - k<0: regime is (-k) zeros followed by a one, length 1-k.
  - Form the unsigned body = {regime, expo, frac} left-aligned into a 63-bit field plus guard bit G and sticky bit S (OR of all dropped bits).
  - Flag sat_hi when k>=62 and sat_lo when k<=-63.
- S2, rounding:
  - RNE: round up iff G && (S || LSB).
  - Increment the 63-bit body. Carry out of bit 62 clamps the result to maxpos 0x7FFF_FFFF_FFFF_FFFF.
  - A rounded result of 0 is forced to minpos 0x0000_0000_0000_0001, since a nonzero value never encodes as zero.
  - sat_hi forces maxpos; sat_lo forces minpos.
- S3, sign and specials:
  - If in_sign=1, out_posit = two's complement of {0, body}; otherwise {0, body}.
  - Priority: in_nar gives 0x8000_0000_0000_0000, else in_zero gives 0x0, else the encoded body.
  - in_sign is ignored for zero and NaR.
- Out-of-range in_regi (-64): treated as sat_lo. in_expo/in_frac bits that fall beyond the word are absorbed into G/S.
- Simultaneous in_nar and in_zero: NaR wins.

Optional Feature:
- Macro POSIT_ENC_ROUND_EN.
- Defined: RNE rounding as above.
- Undefined: truncation. G and S are ignored, no increment and no overflow clamp. The zero-to-minpos rule and the sat_hi/sat_lo forcing remain.
- Latency is 3 cycles either way; S2 becomes a plain register.

Decomposition:
- Package posit_64_4_pkg holds:
  - constants N, ES, RS, FS
  - MAXPOS, MINPOS and NAR localparams
  - a packed struct typedef for decoded fields (sign, regi, expo, frac, zero, nar)
- Sub-module posit_round_rne: combinational RNE on a 63-bit body with G/S. It outputs the rounded body and an overflow flag, and is instantiated in S2.

Test Plan:
- k=0, expo=0, frac=0, sign=0 -> 0x4000_0000_0000_0000. Same fields with sign=1 -> 0xC000_0000_0000_0000.
- k=-1, expo=0, frac=0 -> 0x2000_0000_0000_0000. k=62 -> 0x7FFF_FFFF_FFFF_FFFF. k=-63 -> 0x0000_0000_0000_0001.
- k=1, expo=0:
  - frac=57'h1 (tie, LSB even) -> 0x6000_0000_0000_0000
  - frac=57'h3 (tie, LSB odd) -> 0x6000_0000_0000_0002
  - without POSIT_ENC_ROUND_EN, frac=57'h3 -> 0x6000_0000_0000_0001
- in_nar=1 with in_zero=1 -> 0x8000_0000_0000_0000. in_zero=1, sign=1 -> 0x0.
- Back-to-back stream of 8 inputs with out_ready toggling randomly -> outputs arrive in order, none dropped or duplicated, out_posit stable while out_valid && !out_ready, latency 3 when unstalled.
- Reset asserted with 3 words in flight -> next cycle out_valid=0, out_posit=0, in_ready=1; the first post-reset input appears after exactly 3 cycles.
